// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared width default and FSM encoding for serial_adder
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one operand bit per clock, LSB first
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  full_adder u_fa (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last_bit = (cnt == LAST);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and status outputs decoded from the current state
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-bit shift/accumulate, and result publication on the final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            work  <= '0;
            cnt   <= '0;
          end
        end
        ADD: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          carry <= fa_c;
          work  <= {fa_s, work[WIDTH-1:1]};
          if (last_bit) begin
            // Result registers only move here, so no partial sum is ever visible
            sum  <= {fa_s, work[WIDTH-1:1]};
            cout <= fa_c;
            cnt  <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        DONE: begin
          cnt <= '0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH 8 and 16
module tb_serial_adder;

  localparam int W8  = 8;
  localparam int W16 = 16;

  typedef struct {
    logic [63:0] res;
    int          acc;
  } exp_t;

  logic clk;
  logic rst;

  logic           s8,  cin8,  cout8,  busy8,  done8;
  logic [W8-1:0]  a8,  b8,  sum8;
  logic           s16, cin16, cout16, busy16, done16;
  logic [W16-1:0] a16, b16, sum16;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int   f8 = 0, f16 = 0;
  int   run8 = 0, run16 = 0;
  int   n_done8 = 0;
  int   last_done8 = 0, prev_done8 = 0;

  serial_adder #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
  );

  serial_adder #(.WIDTH(W16)) dut16 (
    .clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16), .cin(cin16),
    .sum(sum16), .cout(cout16), .busy(busy16), .done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Scoreboard for the 8-bit instance: model acceptance, then match each done pulse
  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
      f8   = 0;
      run8 = 0;
    end else begin
      if (s8 && cyc + 1 >= f8) begin
        q8.push_back('{64'(a8) + 64'(b8) + 64'(cin8), cyc + 1});
        f8 = cyc + 1 + W8 + 2;
      end
      if (busy8) run8++;
      if (done8) begin
        check("busy8_with_done", 64'(busy8), 0);
        if (q8.size() == 0) begin
          check("done8_unexpected", 1, 0);
        end else begin
          e8 = q8.pop_front();
          check("result8", {cout8, sum8}, e8.res);
          check("latency8", 64'(cyc - e8.acc), W8);
          check("busy_len8", 64'(run8), W8);
        end
        run8       = 0;
        prev_done8 = last_done8;
        last_done8 = cyc;
        n_done8++;
      end
    end
  end

  // Scoreboard for the 16-bit instance
  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      f16   = 0;
      run16 = 0;
    end else begin
      if (s16 && cyc + 1 >= f16) begin
        q16.push_back('{64'(a16) + 64'(b16) + 64'(cin16), cyc + 1});
        f16 = cyc + 1 + W16 + 2;
      end
      if (busy16) run16++;
      if (done16) begin
        check("busy16_with_done", 64'(busy16), 0);
        if (q16.size() == 0) begin
          check("done16_unexpected", 1, 0);
        end else begin
          e16 = q16.pop_front();
          check("result16", {cout16, sum16}, e16.res);
          check("latency16", 64'(cyc - e16.acc), W16);
          check("busy_len16", 64'(run16), W16);
        end
        run16 = 0;
      end
    end
  end

  task automatic start8(input logic [W8-1:0] av, input logic [W8-1:0] bv, input logic cv);
    @(posedge clk); #2;
    a8 = av; b8 = bv; cin8 = cv; s8 = 1'b1;
    @(posedge clk); #2;
    s8 = 1'b0;
  endtask

  task automatic drain8();
    for (int i = 0; i < 60 && q8.size() != 0; i++) @(posedge clk);
    check("drain8", 64'(q8.size()), 0);
    @(negedge clk);
  endtask

  task automatic drain16();
    for (int i = 0; i < 80 && q16.size() != 0; i++) @(posedge clk);
    check("drain16", 64'(q16.size()), 0);
    @(negedge clk);
  endtask

  task automatic rand8(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #2;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); s8 = 1'b1;
      for (int k = 0; k < W8 + 1; k++) begin
        @(posedge clk); #2;
        s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
    end
  endtask

  task automatic rand16(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #2;
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); s16 = 1'b1;
      for (int k = 0; k < W16 + 1; k++) begin
        @(posedge clk); #2;
        s16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      end
    end
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    s8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    s16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    repeat (3) @(negedge clk);
    check("rst_sum8",   {cout8, sum8}, 0);
    check("rst_busy8",  64'(busy8), 0);
    check("rst_done8",  64'(done8), 0);
    check("rst_sum16",  {cout16, sum16}, 0);
    check("rst_flags16", {busy16, done16}, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Overflow across all bits
    start8(8'hFF, 8'h01, 1'b0);
    drain8();
    check("ff_plus_01", {cout8, sum8}, 9'h100);

    // Alternating patterns with and without carry-in
    start8(8'h5A, 8'hA5, 1'b1);
    drain8();
    check("5a_a5_c1", {cout8, sum8}, 9'h100);
    start8(8'h5A, 8'hA5, 1'b0);
    drain8();
    check("5a_a5_c0", {cout8, sum8}, 9'h0FF);

    // start held high: only idle-state starts are taken
    d0 = n_done8;
    @(posedge clk); #2;
    a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0; s8 = 1'b1;
    repeat (20) @(posedge clk);
    #2 s8 = 1'b0;
    drain8();
    check("held_done_count", 64'(n_done8 - d0), 2);
    check("held_spacing", 64'(last_done8 - prev_done8), W8 + 2);
    check("held_sum", {cout8, sum8}, 9'h007);

    // Operands wiggle during ADD; result registers must hold the old value
    @(posedge clk); #2;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; s8 = 1'b1;
    for (int k = 0; k < W8 - 1; k++) begin
      @(posedge clk); #2;
      s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
      check("hold_during_add", {cout8, sum8}, 9'h007);
    end
    drain8();
    check("wiggle_sum", {cout8, sum8}, 9'h030);

    // Reset on the 4th ADD cycle aborts with outputs cleared asynchronously
    @(posedge clk); #2;
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1; s8 = 1'b1;
    @(posedge clk); #2;
    s8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_result", {cout8, sum8}, 0);
    check("abort_flags", {busy8, done8}, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    start8(8'd1, 8'd1, 1'b0);
    drain8();
    check("after_reset_sum", {cout8, sum8}, 9'h002);

    // Random regression on both widths with operands changing mid-operation
    fork
      rand8(1000);
      rand16(1000);
    join
    drain8();
    drain16();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 SHALL have the port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have the port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have the port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have the port a  input  WIDTH  operand A; captured on an accepted start.
REQ-006 SHALL have the port b  input  WIDTH  operand B; captured on an accepted start.
REQ-007 SHALL have the port cin  input  1  carry-in; captured on an accepted start.
REQ-008 SHALL have the port sum  output  WIDTH  registered result; holds its value between completions.
REQ-009 SHALL have the port cout  output  1  registered carry-out; holds its value between completions.
REQ-010 SHALL have the port busy  output  1  high while in ADD.
REQ-011 SHALL have the port done  output  1  one-cycle pulse marking that sum and cout have just updated.
REQ-012 SHALL use one clock, with reset asynchronous and active-high.

Function
REQ-013 SHALL implement an FSM with states IDLE, ADD and DONE.
REQ-014 In IDLE with start=1, the rising edge SHALL load the a/b shift registers and the carry flop (from cin), clear the bit counter, and enter ADD.
REQ-015 In ADD, each edge SHALL add the LSBs of the a/b shift registers and the carry flop in one full adder, shift the sum bit into the MSB of the working sum register, shift a and b right by one, and load the carry flop with the adder carry.
REQ-016 On the edge that processes bit WIDTH-1, the FSM SHALL enter DONE and load sum from the completed working register and cout from the final carry.
REQ-017 done SHALL be high for exactly the one cycle spent in DONE; the next edge SHALL return the FSM to IDLE.
REQ-018 Latency SHALL be fixed: done rises exactly WIDTH edges after the edge that accepted start, and the next start is accepted no earlier than WIDTH+2 edges after the previous accepted start.
REQ-019 start SHALL be ignored in ADD and DONE, with no restart and no queuing.
REQ-020 Changes on a, b or cin after start is accepted SHALL NOT affect the result in progress.
REQ-021 sum and cout SHALL change only on entry to DONE or on reset; they SHALL NOT show partial results during ADD.
REQ-022 The result SHALL equal the arithmetic {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-023 busy and done SHALL never be high in the same cycle.

Reset
REQ-024 While rst is high, the state SHALL be IDLE, and sum, cout, busy, done, the counter, the shift registers and the carry flop SHALL all be 0.
REQ-025 An rst assertion during ADD or DONE SHALL abort the operation immediately, with no done pulse and outputs forced to 0.
REQ-026 The first start accepted after rst deasserts SHALL behave exactly as after power-up.

Structure
REQ-027 The state encodings (IDLE=0, ADD=1, DONE=2, 2 bits) SHALL be defined once in the shared package/header, together with the default WIDTH.
REQ-028 The per-bit add SHALL use one instance of the team's existing full_adder module (ports x, y, cin, s, cout), with no other adder logic in the block.
REQ-029 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL wrap to 0 on DONE.

Verification
REQ-030 WIDTH=8, a=8'hFF, b=8'h01, cin=0, start for one cycle -> busy high for 8 cycles, then done for one cycle with sum=8'h00 and cout=1.
REQ-031 WIDTH=8, a=8'h5A, b=8'hA5, cin=1 -> sum=8'h00 and cout=1; with cin=0 -> sum=8'hFF and cout=0.
REQ-032 Hold start high for 20 cycles with a=3 and b=4 -> exactly two completions, each with sum=7, spaced 10 edges apart, with no done in between.
REQ-033 Change a and b on every cycle during ADD after starting with a=8'h10 and b=8'h20 -> sum=8'h30 and cout=0; sum keeps its prior value until done.
REQ-034 Assert rst on the 4th ADD cycle -> all outputs go to 0 asynchronously with no done pulse; a fresh start after release with a=1 and b=1 gives sum=2.
REQ-035 Random regression: 1000 random a, b and cin at WIDTH=8 and WIDTH=16 -> every result matches a+b+cin, and done latency always equals WIDTH.
